// File: rtl/lcd_bus_responder.sv
// HD44780-style responder for the 8-bit character-LCD bus.
// Holds the 80-byte DDRAM, address counter and flags, and emulates busy.
module lcd_bus_responder #(
    parameter int BUSY_CMD = 4,
    parameter int BUSY_CLR = 160
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_EN,
    input  logic       i_RS,
    input  logic       i_RW,
    input  logic [7:0] i_DATA,
    output logic [7:0] o_DATA,
    output logic       o_DATA_OE,
    input  logic [6:0] i_rd_addr,
    output logic [7:0] o_rd_char,
    output logic [6:0] o_ac,
    output logic       o_busy,
    output logic       o_disp_on,
    output logic       o_cursor_on,
    output logic       o_blink_on,
    output logic       o_err
);

    localparam int CLR_N = (BUSY_CLR > 80) ? BUSY_CLR : 80;
    localparam int MAXN  = (CLR_N > BUSY_CMD) ? CLR_N : BUSY_CMD;
    localparam int CW    = $clog2(MAXN + 1);

    localparam logic [CW-1:0] CMD_LD  = CW'(BUSY_CMD - 1);
    localparam logic [CW-1:0] HOME_LD = CW'(BUSY_CLR - 1);
    localparam logic [CW-1:0] CLR_LD  = CW'(CLR_N - 1);
    localparam logic [6:0]    LAST    = 7'd79;

    typedef enum logic [1:0] {
        INIT_FILL,
        IDLE,
        BUSY,
        CLR_FILL
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [6:0]    fill, fill_n;
    logic [6:0]    ac, ac_n;
    logic          id, id_n;
    logic          dd, dd_n;
    logic          dsp, dsp_n;
    logic          cur, cur_n;
    logic          blk, blk_n;
    logic          err_n;
    logic          en_q, rs_q, oe;
    logic [7:0]    mem [0:79];
    logic          mem_we;
    logic [6:0]    mem_wa;
    logic [7:0]    mem_wd;
    logic          fall, busy;
    logic          cmd_wr, dat_wr, dat_rd, viol;

    function automatic logic [6:0] idx_of(input logic [6:0] a);
        return a[6] ? 7'd40 + {1'b0, a[5:0]} : {1'b0, a[5:0]};
    endfunction

    function automatic logic ac_valid(input logic [6:0] a);
        return a[5:0] < 6'd40;
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] a,
                                           input logic up);
        logic [6:0] r;
        if (up)
            r = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
        else
            r = (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
        return r;
    endfunction

    assign fall   = ~i_EN & en_q;
    assign busy   = (state != IDLE);
    assign cmd_wr = fall & ~i_RS & ~i_RW;
    assign dat_wr = fall & i_RS & ~i_RW;
    assign dat_rd = fall & i_RS & i_RW;
    assign viol   = (cmd_wr | dat_wr | dat_rd) & busy;

    // Next state: fill/busy sequencing, then decode of a committed transfer
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        fill_n  = fill;
        ac_n    = ac;
        id_n    = id;
        dd_n    = dd;
        dsp_n   = dsp;
        cur_n   = cur;
        blk_n   = blk;
        err_n   = 1'b0;
        mem_we  = 1'b0;
        mem_wa  = fill;
        mem_wd  = 8'h20;
        case (state)
            INIT_FILL: begin
                mem_we = 1'b1;
                if (fill == LAST) begin
                    fill_n  = '0;
                    state_n = IDLE;
                end else begin
                    fill_n = fill + 7'd1;
                end
            end
            CLR_FILL: begin
                mem_we = 1'b1;
                if (cnt != '0)
                    cnt_n = cnt - 1'b1;
                if (fill == LAST) begin
                    fill_n  = '0;
                    state_n = (cnt == '0) ? IDLE : BUSY;
                end else begin
                    fill_n = fill + 7'd1;
                end
            end
            BUSY: begin
                if (cnt == '0)
                    state_n = IDLE;
                else
                    cnt_n = cnt - 1'b1;
            end
            default: begin
            end
        endcase
        if (viol) begin
            err_n = 1'b1;
        end else if (cmd_wr) begin
            state_n = BUSY;
            cnt_n   = CMD_LD;
            unique case (1'b1)
                (i_DATA == 8'h01): begin
                    state_n = CLR_FILL;
                    fill_n  = '0;
                    cnt_n   = CLR_LD;
                    ac_n    = '0;
                    id_n    = 1'b1;
                    dd_n    = 1'b1;
                end
                (i_DATA[7:1] == 7'h01): begin
                    cnt_n = HOME_LD;
                    ac_n  = '0;
                    dd_n  = 1'b1;
                end
                (i_DATA[7:2] == 6'h01): begin
                    id_n = i_DATA[1];
                end
                (i_DATA[7:3] == 5'h01): begin
                    dsp_n = i_DATA[2];
                    cur_n = i_DATA[1];
                    blk_n = i_DATA[0];
                end
                (i_DATA[7:4] == 4'h1): begin
                    if (!i_DATA[3])
                        ac_n = ac_step(ac, i_DATA[2]);
                end
                (i_DATA[7:5] == 3'h1): begin
                end
                (i_DATA[7:6] == 2'h1): begin
                    dd_n = 1'b0;
                end
                i_DATA[7]: begin
                    if (ac_valid(i_DATA[6:0])) begin
                        ac_n = i_DATA[6:0];
                        dd_n = 1'b1;
                    end else begin
                        err_n   = 1'b1;
                        state_n = state;
                        cnt_n   = cnt;
                    end
                end
                default: begin
                end
            endcase
        end else if (dat_wr | dat_rd) begin
            state_n = BUSY;
            cnt_n   = CMD_LD;
            if (dd) begin
                ac_n = ac_step(ac, id);
                if (dat_wr) begin
                    mem_we = 1'b1;
                    mem_wa = idx_of(ac);
                    mem_wd = i_DATA;
                end
            end
        end
    end

    // FSM state, busy counter and fill pointer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= INIT_FILL;
            cnt   <= '0;
            fill  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            fill  <= fill_n;
        end
    end

    // Address counter, flags, error pulse and bus edge/drive tracking
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ac   <= '0;
            id   <= 1'b1;
            dd   <= 1'b1;
            dsp  <= 1'b0;
            cur  <= 1'b0;
            blk  <= 1'b0;
            o_err <= 1'b0;
            en_q <= 1'b0;
            rs_q <= 1'b0;
            oe   <= 1'b0;
        end else begin
            ac   <= ac_n;
            id   <= id_n;
            dd   <= dd_n;
            dsp  <= dsp_n;
            cur  <= cur_n;
            blk  <= blk_n;
            o_err <= err_n;
            en_q <= i_EN;
            rs_q <= i_RS;
            oe   <= i_EN & i_RW;
        end
    end

    // DDRAM write port, shared by fills and data writes
    always_ff @(posedge i_clk) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
    end

    // Checker read port, one cycle latency
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_rd_char <= 8'h00;
        else if (ac_valid(i_rd_addr))
            o_rd_char <= mem[idx_of(i_rd_addr)];
        else
            o_rd_char <= 8'h00;
    end

    assign o_DATA_OE   = oe;
    assign o_DATA      = !oe ? 8'h00 :
                         rs_q ? mem[idx_of(ac)] : {busy, ac};
    assign o_ac        = ac;
    assign o_busy      = busy;
    assign o_disp_on   = dsp;
    assign o_cursor_on = cur;
    assign o_blink_on  = blk;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Bench for lcd_bus_responder: directed scenarios plus random traffic
// checked against a position-based model of the LCD.
module tb_lcd_bus_responder;

    localparam int BC   = 4;
    localparam int BL   = 160;
    localparam int CLRN = 160;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, rs, rw;
    logic [7:0] din;
    logic [7:0] dout;
    logic       oe;
    logic [6:0] rd_addr;
    logic [7:0] rd_char;
    logic [6:0] ac;
    logic       busy, disp_on, cursor_on, blink_on, err;

    lcd_bus_responder dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_EN        (en),
        .i_RS        (rs),
        .i_RW        (rw),
        .i_DATA      (din),
        .o_DATA      (dout),
        .o_DATA_OE   (oe),
        .i_rd_addr   (rd_addr),
        .o_rd_char   (rd_char),
        .o_ac        (ac),
        .o_busy      (busy),
        .o_disp_on   (disp_on),
        .o_cursor_on (cursor_on),
        .o_blink_on  (blink_on),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         busy_end = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         in_rst = 1'b1;
    logic [7:0] m_mem [80];
    int         m_ac;
    bit         m_id, m_dd, m_d, m_c, m_b;

    function automatic int pos_of(int a);
        return (a >= 64) ? a - 24 : a;
    endfunction

    function automatic int addr_of(int p);
        return (p < 40) ? p : p + 24;
    endfunction

    function automatic int advance(int a, bit up);
        int p;
        p = pos_of(a);
        p = up ? (p + 1) % 80 : (p + 79) % 80;
        return addr_of(p);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)",
                   tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        bit eb;
        @(posedge clk);
        #1;
        cyc++;
        eb = in_rst || (cyc <= busy_end);
        chk("busy", busy, eb);
    endtask

    task automatic chk_flags();
        chk("disp_on", disp_on, m_d);
        chk("cursor_on", cursor_on, m_c);
        chk("blink_on", blink_on, m_b);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
        m_ac = 0;
        m_id = 1'b1;
        m_dd = 1'b1;
        m_d  = 1'b0;
        m_c  = 1'b0;
        m_b  = 1'b0;
    endtask

    task automatic do_reset(int hold);
        rst = 1'b1;
        en  = 1'b0;
        in_rst = 1'b1;
        repeat (hold) step();
        chk("rst_data", dout, 0);
        chk("rst_oe", oe, 0);
        chk("rst_err", err, 0);
        chk("rst_ac", ac, 0);
        chk("rst_char", rd_char, 0);
        model_reset();
        chk_flags();
        rst = 1'b0;
        in_rst = 1'b0;
        busy_end = cyc + 79;
    endtask

    task automatic apply(bit r_s, bit r_w, logic [7:0] d, output bit e);
        int f;
        int a;
        int old_end;
        f = cyc;
        e = 1'b0;
        if (!r_s && r_w) return;
        if (f <= busy_end) begin
            e = 1'b1;
            return;
        end
        old_end = busy_end;
        busy_end = f + BC;
        if (r_s) begin
            if (m_dd) begin
                if (!r_w) m_mem[pos_of(m_ac)] = d;
                m_ac = advance(m_ac, m_id);
            end
        end else if (d == 1) begin
            for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
            m_ac = 0;
            m_id = 1'b1;
            m_dd = 1'b1;
            busy_end = f + CLRN;
        end else if (d < 4) begin
            m_ac = 0;
            m_dd = 1'b1;
            busy_end = f + BL;
        end else if (d < 8) begin
            m_id = d[1];
        end else if (d < 16) begin
            m_d = d[2];
            m_c = d[1];
            m_b = d[0];
        end else if (d < 32) begin
            if (!d[3]) m_ac = advance(m_ac, d[2]);
        end else if (d < 64) begin
            m_ac = m_ac;
        end else if (d < 128) begin
            m_dd = 1'b0;
        end else begin
            a = int'(d) - 128;
            if ((a % 64) < 40) begin
                m_ac = a;
                m_dd = 1'b1;
            end else begin
                e = 1'b1;
                busy_end = old_end;
            end
        end
    endtask

    task automatic xfer(bit r_s, bit r_w, logic [7:0] d);
        bit         e;
        logic [7:0] exp;
        rs  = r_s;
        rw  = r_w;
        din = d;
        en  = 1'b1;
        step();
        chk("oe_hi", oe, r_w);
        if (r_w) begin
            if (r_s)
                exp = m_mem[pos_of(m_ac)];
            else
                exp = {(cyc <= busy_end), 7'(m_ac)};
            chk("rdata", dout, exp);
        end
        step();
        en = 1'b0;
        apply(r_s, r_w, d, e);
        step();
        chk("err", err, e);
        chk("oe_lo", oe, 0);
        chk("ac", ac, m_ac);
        chk_flags();
        step();
        chk("err_pulse", err, 0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && cyc <= busy_end; i++) step();
    endtask

    task automatic chk_char(int a);
        rd_addr = 7'(a);
        step();
        chk("char", rd_char, m_mem[pos_of(a)]);
    endtask

    task automatic chk_all();
        for (int p = 0; p < 80; p++) chk_char(addr_of(p));
    endtask

    initial begin
        int         k;
        logic [7:0] d;
        rst = 1'b1;
        en = 1'b0;
        rs = 1'b0;
        rw = 1'b0;
        din = 8'h00;
        rd_addr = 7'h00;

        do_reset(3);
        repeat (85) step();
        chk_char(8'h00);
        chk_char(8'h27);
        chk_char(8'h40);
        chk_char(8'h67);

        xfer(0, 0, 8'h80); wait_idle();
        xfer(1, 0, 8'h41); wait_idle();
        xfer(1, 0, 8'h42); wait_idle();
        chk_char(8'h00);
        chk_char(8'h01);

        xfer(0, 0, 8'hA7); wait_idle();
        xfer(1, 0, 8'h5A); wait_idle();
        xfer(1, 0, 8'h5A); wait_idle();
        chk_char(8'h27);
        chk_char(8'h40);
        xfer(0, 0, 8'h04); wait_idle();
        xfer(0, 0, 8'h80); wait_idle();
        xfer(1, 0, 8'h31); wait_idle();
        chk_char(8'h00);

        xfer(0, 0, 8'h0E);
        xfer(0, 1, 8'h00);
        wait_idle();
        xfer(1, 0, 8'h58);
        xfer(1, 0, 8'h59);
        wait_idle();
        chk_char(8'h67);
        chk_char(8'h66);

        xfer(0, 0, 8'h06); wait_idle();
        xfer(0, 0, 8'h80); wait_idle();
        for (int i = 0; i < 10; i++) begin
            xfer(1, 0, 8'($urandom_range(33, 126)));
            wait_idle();
        end
        xfer(0, 0, 8'h01);
        wait_idle();
        chk_all();
        xfer(0, 0, 8'hA8);
        wait_idle();

        for (int t = 0; t < 80; t++) begin
            k = $urandom_range(0, 10);
            if (k <= 3) begin
                xfer(1, 0, 8'($urandom_range(33, 126)));
            end else if (k == 4) begin
                d = 8'h80 | 8'($urandom_range(0, 127));
                xfer(0, 0, d);
            end else if (k == 5) begin
                xfer(0, 0, 8'h04 | 8'($urandom_range(0, 3)));
            end else if (k == 6) begin
                xfer(0, 1, 8'h00);
            end else if (k == 7) begin
                xfer(1, 1, 8'h00);
            end else if (k == 8) begin
                xfer(0, 0, 8'h10 | 8'($urandom_range(0, 15)));
            end else if (k == 9) begin
                xfer(0, 0, 8'h08 | 8'($urandom_range(0, 7)));
            end else begin
                xfer(0, 0, 8'h40 | 8'($urandom_range(0, 63)));
            end
            repeat ($urandom_range(0, 4)) step();
        end
        wait_idle();
        chk_all();

        xfer(0, 0, 8'h01);
        repeat (30) step();
        do_reset(2);
        repeat (85) step();
        chk_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
